// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fetch_pc_gen_if                                                 |
// | Brief  : Fetch-side bundle between the PC generator, decode and I-cache. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface fetch_pc_gen_if #(
  parameter int PC_WIDTH      = 32,
  parameter int CACHE_DEEPTHE = 12
);
  logic                     iStall;
  logic                     iRedirect;
  logic [PC_WIDTH-1:0]      iRedirectPc;
  logic [CACHE_DEEPTHE-1:0] oInsAddr;
  logic [PC_WIDTH-1:0]      oPc;
  logic                     oRstingBlk;
  logic                     oInsVld;
  logic [PC_WIDTH-1:0]      oInsPc;
  logic                     oMisalign;
  logic [31:0]              oFetchCnt;

  modport master (
    input  iStall, iRedirect, iRedirectPc,
    output oInsAddr, oPc, oRstingBlk, oInsVld, oInsPc, oMisalign, oFetchCnt
  );

  modport slave (
    output iStall, iRedirect, iRedirectPc,
    input  oInsAddr, oPc, oRstingBlk, oInsVld, oInsPc, oMisalign, oFetchCnt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fetch_pc_gen                                                    |
// | Brief  : Fetch PC generator; optional delivery counter FETCH_PERF_CNT_EN.|
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_pc_gen #(
  parameter int                  PC_WIDTH       = 32,
  parameter int                  CACHE_DEEPTHE  = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
  parameter int                  RST_BLK_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rstn,
  fetch_pc_gen_if.master  bus
);

  typedef enum logic [0:0] {
    ST_BLK = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  localparam logic [7:0]          c_blk_last = 8'(RST_BLK_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] c_pc_step  = PC_WIDTH'(4);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_blk_cnt;
  logic [7:0]          w_blk_cnt_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] r_ins_pc;
  logic [PC_WIDTH-1:0] w_ins_pc_nxt;
  logic                r_ins_vld;
  logic                w_ins_vld_nxt;
  logic                r_rsting_blk;
  logic                r_misalign;
  logic                w_misalign_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_BLK;
      r_blk_cnt    <= 8'd0;
      r_pc         <= RESET_PC;
      r_ins_pc     <= RESET_PC;
      r_ins_vld    <= 1'b0;
      r_rsting_blk <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_blk_cnt    <= w_blk_cnt_nxt;
      r_pc         <= w_pc_nxt;
      r_ins_pc     <= w_ins_pc_nxt;
      r_ins_vld    <= w_ins_vld_nxt;
      r_rsting_blk <= (w_state_nxt == ST_RUN);
      r_misalign   <= w_misalign_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_blk_cnt_nxt  = r_blk_cnt;
    w_pc_nxt       = r_pc;
    w_ins_pc_nxt   = r_ins_pc;
    w_ins_vld_nxt  = r_ins_vld;
    w_misalign_nxt = 1'b0;

    case (r_state)
      ST_BLK: begin
        w_blk_cnt_nxt = r_blk_cnt + 8'd1;
        if (r_blk_cnt == c_blk_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.iStall) begin
          w_pc_nxt      = r_pc + c_pc_step;
          w_ins_pc_nxt  = r_pc;
          w_ins_vld_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_BLK;
    endcase

    // Redirect overrides both stall and sequential fetch, and kills the
    // instruction whose SRAM read is in flight; the BLK countdown is untouched.
    if (bus.iRedirect) begin
      w_pc_nxt       = {bus.iRedirectPc[PC_WIDTH-1:2], 2'b00};
      w_ins_pc_nxt   = r_ins_pc;
      w_ins_vld_nxt  = 1'b0;
      w_misalign_nxt = |bus.iRedirectPc[1:0];
    end
  end

  assign bus.oInsAddr   = r_pc[CACHE_DEEPTHE+1:2];
  assign bus.oPc        = r_pc;
  assign bus.oInsPc     = r_ins_pc;
  assign bus.oInsVld    = r_ins_vld;
  assign bus.oRstingBlk = r_rsting_blk;
  assign bus.oMisalign  = r_misalign;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fetch_cnt <= 32'd0;
    end else if (r_ins_vld && !bus.iStall) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign bus.oFetchCnt = r_fetch_cnt;
`else
  assign bus.oFetchCnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_fetch_pc_gen                                                 |
// | Brief  : Self-checking bench for fetch_pc_gen against a behavioural model.|
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fetch_pc_gen;

  localparam int          PW   = 32;
  localparam int          CD   = 12;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam int          NBLK = 4;

  logic clk;
  logic rstn;
  int   errors;
  int   checks;

  fetch_pc_gen_if #(.PC_WIDTH(PW), .CACHE_DEEPTHE(CD)) bus ();

  fetch_pc_gen #(
    .PC_WIDTH(PW), .CACHE_DEEPTHE(CD), .RESET_PC(RPC), .RST_BLK_CYCLES(NBLK)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: remaining masked cycles, current PC, last delivered PC.
  int          m_blk_left;
  logic [31:0] m_pc;
  logic [31:0] m_ins_pc;
  logic        m_vld;
  logic        m_mis;
  logic [31:0] m_cnt;

  function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step(input logic rn, input logic st, input logic rd, input logic [31:0] tgt);
    logic running;
    rstn            = rn;
    bus.iStall      = st;
    bus.iRedirect   = rd;
    bus.iRedirectPc = tgt;
    @(posedge clk);
    if (!rn) begin
      m_blk_left = NBLK;
      m_pc = RPC; m_ins_pc = RPC; m_vld = 1'b0; m_mis = 1'b0; m_cnt = 32'd0;
    end else begin
      running = (m_blk_left == 0);
      if (m_vld && !st) m_cnt = m_cnt + 1;
      if (!running) m_blk_left = m_blk_left - 1;
      if (rd) begin
        m_pc  = tgt & 32'hFFFF_FFFC;
        m_vld = 1'b0;
        m_mis = (tgt % 4) != 0;
      end else begin
        m_mis = 1'b0;
        if (running && !st) begin
          m_ins_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_vld    = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h1234_5677);
    checks++; if (bus.oPc !== RPC) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.oPc, RPC); end
    checks++; if (bus.oInsPc !== RPC) begin errors++; $display("FAIL reset_inspc: got %h want %h", bus.oInsPc, RPC); end
    checks++; if (bus.oInsVld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus.oInsVld); end
    checks++; if (bus.oRstingBlk !== 1'b0) begin errors++; $display("FAIL reset_blk: got %b want 0", bus.oRstingBlk); end
    checks++; if (bus.oMisalign !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", bus.oMisalign); end
    checks++; if (bus.oFetchCnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.oFetchCnt); end
  endtask

  task automatic test_boot();
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (bus.oRstingBlk !== 1'b0) begin errors++; $display("FAIL boot_blk%0d: got %b want 0", k, bus.oRstingBlk); end
      checks++; if (bus.oInsVld !== 1'b0) begin errors++; $display("FAIL boot_vld%0d: got %b want 0", k, bus.oInsVld); end
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.oRstingBlk !== 1'b1) begin errors++; $display("FAIL boot_run_blk: got %b want 1", bus.oRstingBlk); end
    checks++; if (bus.oPc !== 32'h100) begin errors++; $display("FAIL boot_run_pc: got %h want 100", bus.oPc); end
    checks++; if (bus.oInsAddr !== 12'h040) begin errors++; $display("FAIL boot_run_addr: got %h want 040", bus.oInsAddr); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (bus.oInsVld !== 1'b1) begin errors++; $display("FAIL boot_seq_vld%0d: got %b want 1", k, bus.oInsVld); end
      checks++; if (bus.oInsPc !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL boot_seq_pc%0d: got %h want %h", k, bus.oInsPc, 32'h100 + 32'(4 * k)); end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.oPc !== 32'h110) begin errors++; $display("FAIL stall_pre_pc: got %h want 110", bus.oPc); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (bus.oPc !== 32'h110) begin errors++; $display("FAIL stall_pc%0d: got %h want 110", k, bus.oPc); end
      checks++; if (bus.oInsAddr !== 12'h044) begin errors++; $display("FAIL stall_addr%0d: got %h want 044", k, bus.oInsAddr); end
      checks++; if (bus.oInsPc !== 32'h10C) begin errors++; $display("FAIL stall_inspc%0d: got %h want 10c", k, bus.oInsPc); end
      checks++; if (bus.oInsVld !== 1'b1) begin errors++; $display("FAIL stall_vld%0d: got %b want 1", k, bus.oInsVld); end
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.oPc !== 32'h114) begin errors++; $display("FAIL stall_release_pc: got %h want 114", bus.oPc); end
  endtask

  task automatic test_redirect();
    step(1'b1, 1'b1, 1'b1, 32'h0000_2002);
    checks++; if (bus.oPc !== 32'h2000) begin errors++; $display("FAIL redir_pc: got %h want 2000", bus.oPc); end
    checks++; if (bus.oInsVld !== 1'b0) begin errors++; $display("FAIL redir_vld: got %b want 0", bus.oInsVld); end
    checks++; if (bus.oMisalign !== 1'b1) begin errors++; $display("FAIL redir_mis: got %b want 1", bus.oMisalign); end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.oInsPc !== 32'h2000) begin errors++; $display("FAIL redir_inspc: got %h want 2000", bus.oInsPc); end
    checks++; if (bus.oInsVld !== 1'b1) begin errors++; $display("FAIL redir_vld2: got %b want 1", bus.oInsVld); end
    checks++; if (bus.oMisalign !== 1'b0) begin errors++; $display("FAIL redir_mis2: got %b want 0", bus.oMisalign); end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checks++; if (bus.oInsAddr !== 12'hFFF) begin errors++; $display("FAIL wrap_addr0: got %h want fff", bus.oInsAddr); end
    checks++; if (bus.oMisalign !== 1'b0) begin errors++; $display("FAIL wrap_mis: got %b want 0", bus.oMisalign); end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.oInsPc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inspc0: got %h want fffffffc", bus.oInsPc); end
    checks++; if (bus.oInsAddr !== 12'h000) begin errors++; $display("FAIL wrap_addr1: got %h want 000", bus.oInsAddr); end
    checks++; if (bus.oPc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", bus.oPc); end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.oInsPc !== 32'h0) begin errors++; $display("FAIL wrap_inspc1: got %h want 0", bus.oInsPc); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b1, 32'h0000_0300);
    checks++; if (bus.oPc !== 32'h300) begin errors++; $display("FAIL rmid_pre_pc: got %h want 300", bus.oPc); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.oPc !== RPC) begin errors++; $display("FAIL rmid_pc: got %h want %h", bus.oPc, RPC); end
    checks++; if (bus.oInsVld !== 1'b0) begin errors++; $display("FAIL rmid_vld: got %b want 0", bus.oInsVld); end
    checks++; if (bus.oRstingBlk !== 1'b0) begin errors++; $display("FAIL rmid_blk: got %b want 0", bus.oRstingBlk); end
    for (int k = 1; k <= NBLK; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (bus.oRstingBlk !== (k == NBLK)) begin errors++; $display("FAIL rmid_blk%0d: got %b want %b", k, bus.oRstingBlk, k == NBLK); end
    end
  endtask

  task automatic test_perf();
    logic [31:0] want;
`ifdef FETCH_PERF_CNT_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 12; k++) step(1'b1, (k == 3 || k == 7), 1'b0, 32'h0);
    checks++; if (bus.oFetchCnt !== want) begin errors++; $display("FAIL perf_cnt: got %0d want %0d", bus.oFetchCnt, want); end
  endtask

  task automatic test_random();
    logic        rn, st, rd;
    logic [31:0] tgt;
    for (int k = 0; k < 400; k++) begin
      rn  = ($urandom_range(0, 59) != 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      step(rn, st, rd, tgt);
      checks++; if (bus.oPc !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", k, bus.oPc, m_pc); end
      checks++; if (bus.oInsAddr !== m_pc[13:2]) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", k, bus.oInsAddr, m_pc[13:2]); end
      checks++; if (bus.oInsVld !== m_vld) begin errors++; $display("FAIL rnd_vld@%0d: got %b want %b", k, bus.oInsVld, m_vld); end
      checks++; if (m_vld && bus.oInsPc !== m_ins_pc) begin errors++; $display("FAIL rnd_inspc@%0d: got %h want %h", k, bus.oInsPc, m_ins_pc); end
      checks++; if (bus.oRstingBlk !== (m_blk_left == 0)) begin errors++; $display("FAIL rnd_blk@%0d: got %b want %b", k, bus.oRstingBlk, m_blk_left == 0); end
      checks++; if (bus.oMisalign !== m_mis) begin errors++; $display("FAIL rnd_mis@%0d: got %b want %b", k, bus.oMisalign, m_mis); end
      checks++; if (bus.oFetchCnt !== exp_cnt()) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", k, bus.oFetchCnt, exp_cnt()); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    bus.iStall = 1'b0;
    bus.iRedirect = 1'b0;
    bus.iRedirectPc = '0;
    m_blk_left = NBLK;
    m_pc = RPC; m_ins_pc = RPC; m_vld = 1'b0; m_mis = 1'b0; m_cnt = 32'd0;
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
